text_ram_arbiter: RTL and testbench

Arbitrates and sequences the single-port 8-bit text character RAM among four users: the VGA display read path, keyboard character writes, mouse right-click erases and a full-screen clear sweep. It sits between the text editor logic and the text block RAM and keeps a 300-bit occupancy bitmap so the renderer knows which cells hold text. Reset and the clear request both trigger a 300-cycle zero-fill sweep of every valid cell.

---
 rtl/text_ram_pkg.sv | 35 +++
 rtl/text_clear_sweeper.sv | 37 +++
 rtl/text_ram_arbiter.sv | 120 ++++++++++++
 tb/tb_text_ram_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_ram_pkg.sv
// Shared constants, FSM state type and cell-address helpers for the text RAM arbiter.
package text_ram_pkg;

  localparam int unsigned ROWS   = 15;
  localparam int unsigned COLS   = 20;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 5;
  localparam int unsigned CELLS  = ROWS * COLS;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  function automatic logic [ROW_W-1:0] cell_row(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: ROW_W];
  endfunction

  function automatic logic [COL_W-1:0] cell_col(input logic [ADDR_W-1:0] addr);
    return addr[COL_W-1:0];
  endfunction

  function automatic logic cell_valid(input logic [ADDR_W-1:0] addr);
    return (cell_row(addr) < ROW_W'(ROWS)) && (cell_col(addr) < COL_W'(COLS));
  endfunction

  // Linear bitmap index; invalid cells fold onto 0 so the index never leaves the bitmap.
  function automatic logic [ADDR_W-1:0] cell_index(input logic [ADDR_W-1:0] addr);
    if (!cell_valid(addr)) return '0;
    return ADDR_W'(32'(cell_row(addr)) * COLS + 32'(cell_col(addr)));
  endfunction

endpackage

// File: rtl/text_clear_sweeper.sv
// Row-major cell counter that walks every valid text cell once per clear sweep.
module text_clear_sweeper
  import text_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              done_c
);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last_col_c;
  logic             last_row_c;

  assign last_col_c = (col == COL_W'(COLS - 1));
  assign last_row_c = (row == ROW_W'(ROWS - 1));
  assign done_c     = en && last_col_c && last_row_c;
  assign addr       = {row, col};

  always_ff @(posedge clk) begin
    if (rst || start) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (last_col_c) begin
        col <= '0;
        row <= last_row_c ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/text_ram_arbiter.sv
// Sequences the single-port text RAM among display reads, erases, keyboard writes
// and the clear sweep, and keeps the per-cell occupancy bitmap.
module text_ram_arbiter
  import text_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_written,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              erase_req,
  input  logic [ADDR_W-1:0] erase_addr,
  output logic              erase_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_done_c;
  logic [CELLS-1:0]  occ;
  logic [ADDR_W-1:0] last_addr;
  logic              rd_ok_c;
  logic              wr_ok_c;
  logic              er_ok_c;
  logic              rd_zero_c;
  logic              rd_p1_valid;
  logic              rd_p1_zero;
  logic              rd_p1_written;

  assign rd_ok_c   = cell_valid(rd_addr);
  assign wr_ok_c   = cell_valid(wr_addr);
  assign er_ok_c   = cell_valid(erase_addr);
  assign rd_zero_c = (state == CLEAR) || !rd_ok_c;

  text_clear_sweeper u_sweeper (
    .clk    (clk),
    .rst    (rst),
    .start  (clear_req),
    .en     (state == CLEAR),
    .addr   (sweep_addr),
    .done_c (sweep_done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_req)                            state_next = CLEAR;
    else if (state == CLEAR && sweep_done_c)  state_next = SERVE;
  end

  // Grant logic: sweep owns the RAM in CLEAR, otherwise rd > erase > wr.
  always_comb begin
    busy      = 1'b0;
    wr_ack    = 1'b0;
    erase_ack = 1'b0;
    ram_we    = 1'b0;
    ram_din   = '0;
    ram_addr  = last_addr;
    if (rst) begin
      ram_addr = '0;
    end else if (state == CLEAR) begin
      busy     = 1'b1;
      ram_addr = sweep_addr;
      ram_we   = 1'b1;
    end else if (rd_req) begin
      ram_addr = rd_addr;
    end else if (erase_req) begin
      ram_addr  = erase_addr;
      ram_we    = er_ok_c;
      erase_ack = 1'b1;
    end else if (wr_req) begin
      ram_addr = wr_addr;
      ram_din  = wr_data;
      ram_we   = wr_ok_c;
      wr_ack   = 1'b1;
    end
  end

  // Bitmap, held RAM address and the two-stage read return path.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ           <= '0;
      last_addr     <= '0;
      rd_p1_valid   <= 1'b0;
      rd_p1_zero    <= 1'b0;
      rd_p1_written <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      rd_written    <= 1'b0;
    end else begin
      last_addr     <= ram_addr;
      rd_p1_valid   <= rd_req;
      rd_p1_zero    <= rd_zero_c;
      rd_p1_written <= occ[cell_index(rd_addr)] && !rd_zero_c;
      rd_valid      <= rd_p1_valid;
      rd_data       <= rd_p1_zero ? '0 : ram_dout;
      rd_written    <= rd_p1_written;
      if (clear_req)                  occ <= '0;
      else if (erase_ack && er_ok_c)  occ[cell_index(erase_addr)] <= 1'b0;
      else if (wr_ack && wr_ok_c)     occ[cell_index(wr_addr)] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Randomized bench for text_ram_arbiter against a cell-level behavioural model.
module tb_text_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst, clear_req, rd_req, wr_req, erase_req;
  logic [8:0] rd_addr, wr_addr, erase_addr, ram_addr;
  logic [7:0] rd_data, wr_data, ram_din, ram_dout;
  logic       rd_written, rd_valid, wr_ack, erase_ack, busy, ram_we;
  logic [7:0] mem [512];

  always #5 clk = ~clk;

  text_ram_arbiter dut (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_written(rd_written), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .erase_req(erase_req), .erase_addr(erase_addr), .erase_ack(erase_ack),
    .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM attached to the arbiter.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct { int due; logic [7:0] d; bit w; } rd_exp_t;

  int         n_vec = 0, n_err = 0, cyc = 0, rst_held = 0;
  logic [7:0] m_text [300];
  bit         m_occ  [300];
  bit         m_clearing = 1'b1, m_wa, m_ea;
  int         m_pos = 0;
  logic [8:0] m_last = '0;
  rd_exp_t    rq[$];
  logic       s_busy, s_wa, s_ea, s_we, s_rd_valid, s_rd_written;
  logic [7:0] s_rd_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit valid_of(input logic [8:0] a);
    return (int'(a[8:5]) < 15) && (int'(a[4:0]) < 20);
  endfunction

  function automatic int idx_of(input logic [8:0] a);
    return int'(a[8:5]) * 20 + int'(a[4:0]);
  endfunction

  function automatic logic [8:0] addr_of(input int k);
    return {4'(k / 20), 5'(k % 20)};
  endfunction

  function automatic logic [8:0] rand_addr();
    int s = $urandom_range(0, 15);
    if (s == 0) return {4'($urandom_range(0, 15)), 5'($urandom_range(20, 31))};
    if (s == 1) return {4'd15, 5'($urandom_range(0, 31))};
    if (s < 6)  return 9'h025;
    return {4'($urandom_range(0, 14)), 5'($urandom_range(0, 19))};
  endfunction

  task automatic wipe_model();
    for (int i = 0; i < 300; i++) begin
      m_text[i] = 8'h00;
      m_occ[i]  = 1'b0;
    end
  endtask

  // One cycle of the reference model, compared against the DUT mid-cycle.
  task automatic model_check();
    logic [8:0] e_addr;
    logic [7:0] e_din;
    bit         e_we;
    rd_exp_t    r;
    cyc++;
    m_wa = 1'b0;
    m_ea = 1'b0;
    s_busy = busy; s_wa = wr_ack; s_ea = erase_ack; s_we = ram_we;
    s_rd_valid = rd_valid; s_rd_data = rd_data; s_rd_written = rd_written;
    if (rst) begin
      check_eq("rst_busy", busy, 0);
      check_eq("rst_wr_ack", wr_ack, 0);
      check_eq("rst_erase_ack", erase_ack, 0);
      check_eq("rst_ram_we", ram_we, 0);
      check_eq("rst_ram_addr", ram_addr, 0);
      check_eq("rst_ram_din", ram_din, 0);
      if (rst_held > 0) begin
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_rd_written", rd_written, 0);
      end
      rst_held++;
      m_clearing = 1'b1;
      m_pos = 0;
      m_last = '0;
      wipe_model();
      rq.delete();
      return;
    end
    rst_held = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      check_eq("rd_valid", rd_valid, 1);
      check_eq("rd_data", rd_data, r.d);
      check_eq("rd_written", rd_written, r.w);
    end else begin
      check_eq("rd_valid_idle", rd_valid, 0);
    end
    e_we = 1'b0;
    e_din = 8'h00;
    e_addr = m_last;
    if (m_clearing) begin
      e_addr = addr_of(m_pos);
      e_we = 1'b1;
      if (rd_req) rq.push_back('{cyc + 2, 8'h00, 1'b0});
    end else if (rd_req) begin
      e_addr = rd_addr;
      if (valid_of(rd_addr)) rq.push_back('{cyc + 2, m_text[idx_of(rd_addr)], m_occ[idx_of(rd_addr)]});
      else                   rq.push_back('{cyc + 2, 8'h00, 1'b0});
    end else if (erase_req) begin
      m_ea = 1'b1;
      e_addr = erase_addr;
      if (valid_of(erase_addr)) begin
        e_we = 1'b1;
        m_text[idx_of(erase_addr)] = 8'h00;
        m_occ[idx_of(erase_addr)]  = 1'b0;
      end
    end else if (wr_req) begin
      m_wa = 1'b1;
      e_addr = wr_addr;
      e_din = wr_data;
      if (valid_of(wr_addr)) begin
        e_we = 1'b1;
        m_text[idx_of(wr_addr)] = wr_data;
        m_occ[idx_of(wr_addr)]  = 1'b1;
      end
    end
    check_eq("busy", busy, m_clearing);
    check_eq("wr_ack", wr_ack, m_wa);
    check_eq("erase_ack", erase_ack, m_ea);
    check_eq("ram_we", ram_we, e_we);
    check_eq("ram_addr", ram_addr, e_addr);
    if (e_we) check_eq("ram_din", ram_din, e_din);
    m_last = e_addr;
    if (clear_req) begin
      m_clearing = 1'b1;
      m_pos = 0;
      wipe_model();
    end else if (m_clearing) begin
      m_pos++;
      if (m_pos == 300) m_clearing = 1'b0;
    end
  endtask

  // Advance one cycle; acked requests and the clear pulse are withdrawn afterwards.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    if (m_wa) wr_req = 1'b0;
    if (m_ea) erase_req = 1'b0;
  endtask

  task automatic sweep_len(input string tag);
    int  n = 0;
    bit  done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (s_busy === 1'b1) n++;
      else done = 1'b1;
    end
    check_eq(tag, n, 300);
  endtask

  task automatic read_cell(input logic [8:0] a);
    rd_req = 1'b1;
    rd_addr = a;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int acks;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    wipe_model();
    rst = 1'b1; clear_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0; erase_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; erase_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    sweep_len("reset_sweep_len");

    wr_req = 1'b1; wr_addr = 9'h025; wr_data = 8'h41;
    tick();
    check_eq("wr_ack_025", s_wa, 1);
    read_cell(9'h025);
    check_eq("rd_valid_025", s_rd_valid, 1);
    check_eq("rd_data_025", s_rd_data, 8'h41);
    check_eq("rd_written_025", s_rd_written, 1);

    erase_req = 1'b1; erase_addr = 9'h025;
    wr_req = 1'b1; wr_addr = 9'h025; wr_data = 8'h5A;
    tick();
    check_eq("collide_erase_first", s_ea, 1);
    check_eq("collide_wr_waits", s_wa, 0);
    tick();
    check_eq("collide_wr_next", s_wa, 1);
    read_cell(9'h025);
    check_eq("collide_rd_data", s_rd_data, 8'h5A);
    check_eq("collide_rd_written", s_rd_written, 1);

    rd_req = 1'b1; rd_addr = 9'h101;
    wr_req = 1'b1; wr_addr = 9'h030; wr_data = 8'h33;
    acks = 0;
    repeat (6) begin tick(); acks += int'(s_wa); end
    check_eq("starve_no_ack", acks, 0);
    rd_req = 1'b0;
    tick();
    check_eq("starve_release_ack", s_wa, 1);
    tick(); tick();

    clear_req = 1'b1;
    tick();
    wr_req = 1'b1; wr_addr = 9'h040; wr_data = 8'h77;
    repeat (100) tick();
    clear_req = 1'b1;
    tick();
    sweep_len("restart_sweep_len");
    check_eq("wr_after_clear", s_wa, 1);

    wr_req = 1'b1; wr_addr = 9'h015; wr_data = 8'h99;
    tick();
    check_eq("bad_wr_ack", s_wa, 1);
    check_eq("bad_wr_we", s_we, 0);
    read_cell(9'h015);
    check_eq("bad_rd_valid", s_rd_valid, 1);
    check_eq("bad_rd_data", s_rd_data, 0);
    check_eq("bad_rd_written", s_rd_written, 0);

    for (int i = 0; i < 4000; i++) begin
      rst = (i == 2000 || i == 2001);
      rd_req = ($urandom_range(0, 99) < 35);
      rd_addr = rand_addr();
      if ($urandom_range(0, 499) == 0) clear_req = 1'b1;
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req = 1'b1; wr_addr = rand_addr(); wr_data = 8'($urandom);
      end
      if (!erase_req && $urandom_range(0, 5) == 0) begin
        erase_req = 1'b1; erase_addr = rand_addr();
      end
      tick();
    end
    rd_req = 1'b0; wr_req = 1'b0; erase_req = 1'b0; rst = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
